// File: rtl/led_zone_strip_tx.sv
// Zone-to-strip LED frame transmitter: snapshots per-zone mean colours, expands each
// zone into LEDS_PER_ZONE identical LEDs and serialises the frame on cko_o/sdo_o.
// Optional 32-bit zero start-of-frame word: define LED_ZONE_STRIP_SOF_EN.
module led_zone_strip_tx #(
  parameter int unsigned NUM_ZONES     = 8,
  parameter int unsigned COLOR_W       = 4,
  parameter int unsigned LEDS_PER_ZONE = 6,
  parameter int unsigned DIV_CNT       = 5,
  parameter int unsigned WAIT_CNT      = 5
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         en,
  input  logic                         start,
  input  logic [NUM_ZONES*COLOR_W-1:0] mean_r,
  input  logic [NUM_ZONES*COLOR_W-1:0] mean_g,
  input  logic [NUM_ZONES*COLOR_W-1:0] mean_b,
  input  logic                         reverse,
  output logic                         busy,
  output logic                         done,
  output logic                         frame_drop,
  output logic                         cko_o,
  output logic                         sdo_o
);

  localparam int unsigned LED_NUM = NUM_ZONES * LEDS_PER_ZONE;
  localparam int unsigned PH_W    = $clog2(DIV_CNT);
  localparam int unsigned GAP_W   = (WAIT_CNT > 1) ? $clog2(WAIT_CNT) : 1;
  localparam int unsigned LED_W   = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
  localparam int unsigned ZN_W    = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;
  localparam int unsigned REP_W   = (LEDS_PER_ZONE > 1) ? $clog2(LEDS_PER_ZONE) : 1;
  localparam int unsigned BIT_W   = 5;
  localparam int unsigned CKO_HI  = (DIV_CNT + 1) / 2;

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_LEAD, S_DATA, S_TRAIL} state_t;

  state_t           state, state_d;
  logic [PH_W-1:0]  phase, phase_d;
  logic [GAP_W-1:0] gap, gap_d;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_d;
  logic [LED_W-1:0] led_cnt, led_cnt_d;
  logic [ZN_W-1:0]  zone_cnt, zone_cnt_d;
  logic [REP_W-1:0] rep_cnt, rep_cnt_d;
  logic             arm_pend, arm_pend_d;
  logic             sof_act, sof_act_d;
  logic             snap_load;
  logic             busy_d, done_d, drop_d, cko_d, sdo_d;
  logic             phase_end, in_frame;
  logic [ZN_W-1:0]  zone_sel;
  logic [23:0]      word_c, word_sh;

  logic [NUM_ZONES-1:0][COLOR_W-1:0] snap_r, snap_g, snap_b;
  logic                              snap_rev;

  // Channel byte: colour in the MSBs, remaining low bits padded with ones.
  function automatic logic [7:0] chan_byte(input logic [COLOR_W-1:0] c);
    logic [7:0] b;
    b = 8'hFF;
    b[7 -: COLOR_W] = c;
    return b;
  endfunction

  assign phase_end = (phase == PH_W'(DIV_CNT - 1));
  assign in_frame  = (state == S_LEAD) || (state == S_DATA) || (state == S_TRAIL);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next-state, counter updates and next values of the registered outputs.
  always_comb begin
    state_d    = state;
    phase_d    = phase;
    gap_d      = gap;
    bit_cnt_d  = bit_cnt;
    led_cnt_d  = led_cnt;
    zone_cnt_d = zone_cnt;
    rep_cnt_d  = rep_cnt;
    sof_act_d  = sof_act;
    arm_pend_d = arm_pend | (en & in_frame);
    snap_load  = 1'b0;
    done_d     = 1'b0;
    drop_d     = start & (state != S_ARMED);
    busy_d     = 1'b0;
    cko_d      = 1'b0;
    sdo_d      = 1'b0;
    zone_sel   = '0;
    word_c     = '0;
    word_sh    = '0;

    if (in_frame) phase_d = phase_end ? '0 : phase + 1'b1;

    case (state)
      S_IDLE: begin
        if (en) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (start) begin
          state_d   = S_LEAD;
          snap_load = 1'b1;
          phase_d   = '0;
          gap_d     = '0;
        end
      end
      S_LEAD: begin
        if (phase_end) begin
          if (gap == GAP_W'(WAIT_CNT - 1)) begin
            state_d    = S_DATA;
            gap_d      = '0;
            bit_cnt_d  = '0;
            led_cnt_d  = '0;
            zone_cnt_d = '0;
            rep_cnt_d  = '0;
`ifdef LED_ZONE_STRIP_SOF_EN
            sof_act_d  = 1'b1;
`else
            sof_act_d  = 1'b0;
`endif
          end else begin
            gap_d = gap + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (phase_end) begin
          if (sof_act) begin
            if (bit_cnt == BIT_W'(31)) begin
              sof_act_d = 1'b0;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt + 1'b1;
            end
          end else if (bit_cnt == BIT_W'(23)) begin
            bit_cnt_d = '0;
            if (led_cnt == LED_W'(LED_NUM - 1)) begin
              state_d = S_TRAIL;
              gap_d   = '0;
            end else begin
              led_cnt_d = led_cnt + 1'b1;
              // Zone advances after LEDS_PER_ZONE repeats of the same colour.
              if (rep_cnt == REP_W'(LEDS_PER_ZONE - 1)) begin
                rep_cnt_d  = '0;
                zone_cnt_d = zone_cnt + 1'b1;
              end else begin
                rep_cnt_d = rep_cnt + 1'b1;
              end
            end
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
      end
      S_TRAIL: begin
        if (phase_end) begin
          if (gap == GAP_W'(WAIT_CNT - 1)) begin
            state_d    = arm_pend_d ? S_ARMED : S_IDLE;
            arm_pend_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            gap_d = gap + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are derived from next-cycle state so they land registered on time.
    busy_d   = (state_d == S_LEAD) || (state_d == S_DATA) || (state_d == S_TRAIL);
    zone_sel = snap_rev ? ZN_W'(NUM_ZONES - 1) - zone_cnt_d : zone_cnt_d;
    word_c   = {chan_byte(snap_r[zone_sel]), chan_byte(snap_g[zone_sel]),
                chan_byte(snap_b[zone_sel])};
    word_sh  = word_c << bit_cnt_d;
    cko_d    = (state_d == S_DATA) && (phase_d >= PH_W'(CKO_HI));
    sdo_d    = (state_d == S_DATA) && !sof_act_d && word_sh[23];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase    <= '0;
      gap      <= '0;
      bit_cnt  <= '0;
      led_cnt  <= '0;
      zone_cnt <= '0;
      rep_cnt  <= '0;
      arm_pend <= 1'b0;
      sof_act  <= 1'b0;
    end else begin
      phase    <= phase_d;
      gap      <= gap_d;
      bit_cnt  <= bit_cnt_d;
      led_cnt  <= led_cnt_d;
      zone_cnt <= zone_cnt_d;
      rep_cnt  <= rep_cnt_d;
      arm_pend <= arm_pend_d;
      sof_act  <= sof_act_d;
    end
  end

  // Frame snapshot; later input changes cannot disturb a frame in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      snap_r   <= '0;
      snap_g   <= '0;
      snap_b   <= '0;
      snap_rev <= 1'b0;
    end else if (snap_load) begin
      snap_r   <= mean_r;
      snap_g   <= mean_g;
      snap_b   <= mean_b;
      snap_rev <= reverse;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      frame_drop <= 1'b0;
      cko_o      <= 1'b0;
      sdo_o      <= 1'b0;
    end else begin
      busy       <= busy_d;
      done       <= done_d;
      frame_drop <= drop_d;
      cko_o      <= cko_d;
      sdo_o      <= sdo_d;
    end
  end

endmodule
